cam_capture: RTL and testbench
==============================

Name: cam_capture

Overview:
- Parametrised pixel-capture engine for the OV-series camera DVP bus; successor to the fixed-format RGB565 capture path inside the camera controller.
- Synchronises pclk/href/vsync/data into the system clock and assembles 1-4 byte pixels.
- Applies optional power-of-two decimation and crops to the configured active window.
- Presents pixels with linear frame-buffer addresses over a valid/ready handshake, with frame pulses, frame counter and sticky error flags.
- I2C sensor init stays outside this block; `enable_i` is driven by the init-done flag.

Parameters:
- DATA_W, 8: camera data bus width.
- BYTES_PER_PX, 2: bytes per pixel, legal values 1-4; the first byte received is the most significant.
- H_ACTIVE, 640: pixels per line kept before decimation.
- V_ACTIVE, 480: lines per frame kept before decimation.
- DECIM_LOG2, 0: keep 1 of every 2^n pixels and 1 of every 2^n lines; legal values 0-2.
- ADDR_W, 19: width of the output address.
- SYNC_STAGES, 2: synchroniser depth on pclk, href, vsync and data.

Ports:
- clk_i  in  1  system clock, at least 4x pclk.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- enable_i  in  1  capture enable; sampled only at frame boundaries.
- data_i  in  DATA_W  camera data.
- pclk_i  in  1  camera pixel clock, sampled as data.
- href_i  in  1  line valid.
- vsync_i  in  1  frame sync; high during the blanking interval.
- px_data_o  out  BYTES_PER_PX*DATA_W  assembled pixel.
- px_addr_o  out  ADDR_W  linear frame-buffer address.
- px_valid_o  out  1  pixel valid.
- px_ready_i  in  1  sink ready.
- frame_start_o  out  1  1-cycle pulse on the vsync falling edge that starts capture.
- frame_done_o  out  1  1-cycle pulse at the end of a frame.
- frame_cnt_o  out  16  number of completed frames; wraps.
- overrun_o  out  1  sticky flag: a pixel was dropped.
- short_frame_o  out  1  sticky flag: a frame ended with fewer than V_ACTIVE lines.
- clr_err_i  in  1  clears both sticky flags.
- state_o  out  2  debug: the FSM state encoding.

Behaviour:
- Reset: every register and output clears to 0 and the FSM enters IDLE.
- Synchronisers: pclk, href, vsync and data pass through SYNC_STAGES flops, then one extra register for edge detection.
  - A byte strobe is a pclk rising edge with href high in both samples.
- FSM states:
  - IDLE (0): moves to WAIT_VS when enable_i=1.
  - WAIT_VS (1): waits for a vsync falling edge, then pulses frame_start_o, clears all counters and address, and moves to CAPTURE.
  - CAPTURE (2): on a vsync rising edge, moves to DONE.
  - DONE (3): pulses frame_done_o and increments frame_cnt_o. If row count < V_ACTIVE, sets short_frame_o. Moves to WAIT_VS if enable_i=1, otherwise to IDLE.
- Disabling mid-frame: enable_i deasserted during CAPTURE takes effect only at DONE, so the frame completes.
- Byte assembly: a byte index counts 0..BYTES_PER_PX-1 on each strobe. On the last byte the pixel is complete.
  - Data is shifted in from the LSB side, so the first byte ends up in the MSBs.
- Line handling: an href falling edge increments the row, zeroes the column and zeroes the byte index. Any partial pixel is discarded.
- Pixel keep rule: a completed pixel is kept iff all three hold:
  - column < H_ACTIVE;
  - row < V_ACTIVE;
  - column[DECIM_LOG2-1:0]==0 and row[DECIM_LOG2-1:0]==0 (no check when DECIM_LOG2=0).
- Column count: increments on every completed pixel, kept or not, and saturates at H_ACTIVE.
- Output register: a single entry.
  - A kept pixel loads px_data_o/px_addr_o and sets px_valid_o one clk after the last-byte strobe cycle.
  - px_valid_o holds, with data and address stable, until px_valid_o && px_ready_i.
- Overrun: if a kept pixel completes while valid=1 and ready=0, the new pixel is dropped and overrun_o is set.
  - The address still advances, so frame geometry is preserved.
- Simultaneous handoff and new pixel (valid=1, ready=1, new kept pixel in the same cycle): the new pixel loads and there is no overrun.
- Address: starts at 0 each frame and increments once per kept pixel.
  - Maximum value is (H_ACTIVE>>D)*(V_ACTIVE>>D)-1, where D=DECIM_LOG2; it never wraps within a frame.
- Sticky flags: clr_err_i clears both. If clr_err_i coincides with a new error event, the set wins.
- frame_cnt_o wraps from 0xFFFF to 0.

Test Plan:
- Params H=4, V=2, BPP=2, D=0: one frame with bytes 0x11..0x88 on line 0 and 0x91..0x98 on line 1 -> 8 pixels: 0x1122,0x3344,0x5566,0x7788 at addresses 0-3, then 0x9192.. at 4-7; one frame_start_o, one frame_done_o, frame_cnt_o=1.
- Same frame with px_ready_i=0 during pixel 1 -> pixel 0 held stable; pixel 1 dropped; overrun_o=1; pixel 2 at address 2. After clr_err_i, overrun_o=0.
- D=1, H=4, V=4, BPP=1, bytes equal to the column index -> only even columns on even rows are emitted: 2 pixels per kept row, 4 pixels total at addresses 0-3.
- Line with 6 pixels plus a half pixel (H=4) -> columns 4-5 and the partial byte discarded; next line starts at column 0.
- vsync rises after 1 of 2 lines -> short_frame_o=1 and frame_done_o pulses.
- enable_i dropped mid-frame -> frame completes, FSM enters IDLE, the next vsync is ignored. rst_n_i asserted mid-line -> all outputs 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/cam_capture.sv
// DVP camera capture: synchronises the sensor bus into clk_i and assembles pixels.
// Decimates and crops them, then hands each one out with its frame-buffer address.
module cam_capture #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned BYTES_PER_PX = 2,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned DECIM_LOG2   = 0,
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           enable_i,
  input  logic [DATA_W-1:0]              data_i,
  input  logic                           pclk_i,
  input  logic                           href_i,
  input  logic                           vsync_i,
  output logic [BYTES_PER_PX*DATA_W-1:0] px_data_o,
  output logic [ADDR_W-1:0]              px_addr_o,
  output logic                           px_valid_o,
  input  logic                           px_ready_i,
  output logic                           frame_start_o,
  output logic                           frame_done_o,
  output logic [15:0]                    frame_cnt_o,
  output logic                           overrun_o,
  output logic                           short_frame_o,
  input  logic                           clr_err_i,
  output logic [1:0]                     state_o
);
  localparam int unsigned PX_W     = BYTES_PER_PX * DATA_W;
  localparam int unsigned BUS_W    = DATA_W + 3;
  localparam int unsigned COL_W    = $clog2(H_ACTIVE + 1);
  localparam int unsigned ROW_W    = $clog2(V_ACTIVE + 1);
  localparam int unsigned IDX_W    = (BYTES_PER_PX > 1) ? $clog2(BYTES_PER_PX) : 1;
  localparam int unsigned DEC_MASK = (1 << DECIM_LOG2) - 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitVs  = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } state_e;

  logic [BUS_W-1:0] sync [SYNC_STAGES];
  logic [2:0]       prev;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      prev <= '0;
    end else begin
      sync[0] <= {pclk_i, href_i, vsync_i, data_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      prev <= sync[SYNC_STAGES-1][BUS_W-1 -: 3];
    end
  end

  logic              cur_pclk, cur_href, cur_vs;
  logic              prv_pclk, prv_href, prv_vs;
  logic [DATA_W-1:0] cur_data;
  assign {cur_pclk, cur_href, cur_vs, cur_data} = sync[SYNC_STAGES-1];
  assign {prv_pclk, prv_href, prv_vs} = prev;

  state_e            state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] addr;
  logic [PX_W-1:0]   shift;

  logic            strobe, line_end, vs_fall, vs_rise, last_byte, keep;
  logic [PX_W-1:0] px_next;

  assign strobe    = cur_pclk && !prv_pclk && cur_href && prv_href;
  assign line_end  = prv_href && !cur_href;
  assign vs_fall   = prv_vs && !cur_vs;
  assign vs_rise   = !prv_vs && cur_vs;
  assign last_byte = (idx == IDX_W'(BYTES_PER_PX - 1));
  // Older bytes migrate toward the MSBs, so the first byte of a pixel ends on top.
  assign px_next   = (shift << DATA_W) | PX_W'(cur_data);
  assign keep      = (state == StCapture) && strobe && last_byte &&
                     (col < COL_W'(H_ACTIVE)) && (row < ROW_W'(V_ACTIVE)) &&
                     ((col & COL_W'(DEC_MASK)) == '0) && ((row & ROW_W'(DEC_MASK)) == '0);

  assign state_o = state;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= StIdle;
      col           <= '0;
      row           <= '0;
      idx           <= '0;
      addr          <= '0;
      shift         <= '0;
      px_data_o     <= '0;
      px_addr_o     <= '0;
      px_valid_o    <= 1'b0;
      frame_start_o <= 1'b0;
      frame_done_o  <= 1'b0;
      frame_cnt_o   <= '0;
      overrun_o     <= 1'b0;
      short_frame_o <= 1'b0;
    end else begin
      frame_start_o <= 1'b0;
      frame_done_o  <= 1'b0;
      if (px_valid_o && px_ready_i) px_valid_o <= 1'b0;
      // Later assignments below let a coincident error event win over the clear.
      if (clr_err_i) begin
        overrun_o     <= 1'b0;
        short_frame_o <= 1'b0;
      end
      unique case (state)
        StIdle: begin
          if (enable_i) state <= StWaitVs;
        end
        StWaitVs: begin
          if (vs_fall) begin
            frame_start_o <= 1'b1;
            col           <= '0;
            row           <= '0;
            idx           <= '0;
            addr          <= '0;
            state         <= StCapture;
          end
        end
        StCapture: begin
          if (vs_rise) state <= StDone;
          if (line_end) begin
            if (row < ROW_W'(V_ACTIVE)) row <= row + ROW_W'(1);
            col <= '0;
            idx <= '0;
          end else if (strobe) begin
            shift <= px_next;
            if (last_byte) begin
              idx <= '0;
              if (col < COL_W'(H_ACTIVE)) col <= col + COL_W'(1);
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          if (keep) begin
            addr <= addr + ADDR_W'(1);
            if (px_valid_o && !px_ready_i) begin
              overrun_o <= 1'b1;
            end else begin
              px_data_o  <= px_next;
              px_addr_o  <= addr;
              px_valid_o <= 1'b1;
            end
          end
        end
        StDone: begin
          frame_done_o <= 1'b1;
          frame_cnt_o  <= frame_cnt_o + 16'd1;
          if (row < ROW_W'(V_ACTIVE)) short_frame_o <= 1'b1;
          state <= enable_i ? StWaitVs : StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture: two configurations share one camera bus and are compared
// against a frame-level model of pixel grouping, cropping, decimation and addressing.
module tb_cam_capture;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0, pclk = 1'b0, href = 1'b0, vsync = 1'b1, clr_err = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready0 = 1'b1, ready1 = 1'b1;

  logic [15:0] px_data0, fcnt0, fcnt1;
  logic [7:0]  px_data1;
  logic [18:0] px_addr0, px_addr1;
  logic        px_valid0, fs0, fd0, ovr0, sf0;
  logic        px_valid1, fs1, fd1, ovr1, sf1;
  logic [1:0]  st0, st1;

  always #5 clk = ~clk;

  cam_capture #(.DATA_W(8), .BYTES_PER_PX(2), .H_ACTIVE(4), .V_ACTIVE(2), .DECIM_LOG2(0),
                .ADDR_W(19), .SYNC_STAGES(2)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .data_i(data), .pclk_i(pclk),
    .href_i(href), .vsync_i(vsync), .px_data_o(px_data0), .px_addr_o(px_addr0),
    .px_valid_o(px_valid0), .px_ready_i(ready0), .frame_start_o(fs0), .frame_done_o(fd0),
    .frame_cnt_o(fcnt0), .overrun_o(ovr0), .short_frame_o(sf0), .clr_err_i(clr_err),
    .state_o(st0));

  cam_capture #(.DATA_W(8), .BYTES_PER_PX(1), .H_ACTIVE(4), .V_ACTIVE(4), .DECIM_LOG2(1),
                .ADDR_W(19), .SYNC_STAGES(2)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .data_i(data), .pclk_i(pclk),
    .href_i(href), .vsync_i(vsync), .px_data_o(px_data1), .px_addr_o(px_addr1),
    .px_valid_o(px_valid1), .px_ready_i(ready1), .frame_start_o(fs1), .frame_done_o(fd1),
    .frame_cnt_o(fcnt1), .overrun_o(ovr1), .short_frame_o(sf1), .clr_err_i(clr_err),
    .state_o(st1));

  typedef struct packed {logic [31:0] data; logic [31:0] addr;} px_t;
  typedef struct packed {logic [15:0] cnt; logic s0; logic s1; logic o0;} fr_t;

  px_t  q0[$], q1[$], log0[$], log1[$];
  fr_t  qf[$];
  fr_t  cur_f = '0;
  logic [7:0] fb [8][16];
  int   ll [8];
  int   n_chk = 0, n_pass = 0;
  int   starts0 = 0, starts1 = 0, dones0 = 0, dones1 = 0, exp_starts = 0;
  int   stall0 = 0, stall1 = 0, rdy_mode0 = 0;
  bit   chk_en = 1'b1;
  logic exp_s0 = 1'b0, exp_s1 = 1'b0, exp_o0 = 1'b0;
  logic [15:0] exp_cnt = 16'd0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Frame model: lines split into whole pixels, cropped, decimated, numbered in order.
  function automatic void model_push(input int k, input int bpp, input int h, input int v,
                                     input int d, input int nl, input int drop);
    int addr = 0;
    int step = 1 << d;
    for (int r = 0; r < nl; r++) begin
      for (int c = 0; c < ll[r] / bpp; c++) begin
        if (c < h && r < v && c % step == 0 && r % step == 0) begin
          logic [31:0] px = 32'd0;
          for (int b = 0; b < bpp; b++) px = (px << 8) | 32'(fb[r][c*bpp+b]);
          if (addr != drop) begin
            if (k == 0) q0.push_back({px, 32'(addr)});
            else q1.push_back({px, 32'(addr)});
          end
          addr++;
        end
      end
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ready never stays low more than three cycles, so paced pixels are never dropped.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode0 == 1) begin
        ready0 = 1'b0;
        stall0 = 0;
      end else begin
        ready0 = (stall0 >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        stall0 = ready0 ? 0 : stall0 + 1;
      end
      ready1 = (stall1 >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      stall1 = ready1 ? 0 : stall1 + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      if (px_valid0) begin
        if (q0.size() == 0) chk("px0_unexpected", 32'(px_valid0), 32'd0);
        else begin
          chk("px0_data", 32'(px_data0), q0[0].data);
          chk("px0_addr", 32'(px_addr0), q0[0].addr);
          if (ready0) begin
            log0.push_back({32'(px_data0), 32'(px_addr0)});
            void'(q0.pop_front());
          end
        end
      end
      if (px_valid1) begin
        if (q1.size() == 0) chk("px1_unexpected", 32'(px_valid1), 32'd0);
        else begin
          chk("px1_data", 32'(px_data1), q1[0].data);
          chk("px1_addr", 32'(px_addr1), q1[0].addr);
          if (ready1) begin
            log1.push_back({32'(px_data1), 32'(px_addr1)});
            void'(q1.pop_front());
          end
        end
      end
      if (fs0) starts0++;
      if (fs1) starts1++;
      if (fd0) begin
        dones0++;
        if (qf.size() == 0) chk("done0_unexpected", 32'(fd0), 32'd0);
        else begin
          cur_f = qf.pop_front();
          chk("frame_cnt0", 32'(fcnt0), 32'(cur_f.cnt));
          chk("short0", 32'(sf0), 32'(cur_f.s0));
          chk("overrun0", 32'(ovr0), 32'(cur_f.o0));
          chk("overrun1", 32'(ovr1), 32'd0);
        end
      end
      if (fd1) begin
        dones1++;
        chk("frame_cnt1", 32'(fcnt1), 32'(cur_f.cnt));
        chk("short1", 32'(sf1), 32'(cur_f.s1));
      end
    end
  end

  task automatic fill_line(input int r, input int len, input int base, input int step);
    ll[r] = len;
    for (int i = 0; i < len; i++) fb[r][i] = 8'(base + i * step);
  endtask

  task automatic fill_random(input int nl);
    for (int r = 0; r < nl; r++) begin
      ll[r] = $urandom_range(0, 12);
      for (int i = 0; i < ll[r]; i++) fb[r][i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic drive_frame(input int nl, input bit cap, input int drop0, input int rel_byte,
                             input int drop_en_line);
    int d0;
    d0 = dones0;
    log0.delete();
    log1.delete();
    if (cap) begin
      model_push(0, 2, 4, 2, 0, nl, drop0);
      model_push(1, 1, 4, 4, 1, nl, -1);
      exp_cnt++;
      exp_starts++;
      if (nl < 2) exp_s0 = 1'b1;
      if (nl < 4) exp_s1 = 1'b1;
      if (drop0 >= 0) exp_o0 = 1'b1;
      qf.push_back({exp_cnt, exp_s0, exp_s1, exp_o0});
    end
    vsync = 1'b0;
    cyc(10);
    for (int r = 0; r < nl; r++) begin
      if (r == drop_en_line) enable = 1'b0;
      href = 1'b1;
      pclk = 1'b0;
      for (int i = 0; i < ll[r]; i++) begin
        data = fb[r][i];
        pclk = 1'b0;
        cyc(4);
        pclk = 1'b1;
        cyc(4);
        if (r == 0 && i == rel_byte) rdy_mode0 = 0;
      end
      pclk = 1'b0;
      cyc(4);
      href = 1'b0;
      cyc(10);
    end
    vsync = 1'b1;
    for (int t = 0; t < 40 && dones0 == d0; t++) cyc(1);
    cyc(10);
    chk("frame_done_count0", 32'(dones0), 32'(d0 + (cap ? 1 : 0)));
    chk("frame_done_count1", 32'(dones1), 32'(dones0));
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("starts0", 32'(starts0), 32'(exp_starts));
    chk("starts1", 32'(starts1), 32'(exp_starts));
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    exp_s0 = 1'b0;
    exp_s1 = 1'b0;
    exp_o0 = 1'b0;
    chk("clr_overrun0", 32'(ovr0), 32'd0);
    chk("clr_short0", 32'(sf0), 32'd0);
    chk("clr_short1", 32'(sf1), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state0"}, 32'(st0), 32'd0);
    chk({tag, "_state1"}, 32'(st1), 32'd0);
    chk({tag, "_valid0"}, 32'(px_valid0), 32'd0);
    chk({tag, "_valid1"}, 32'(px_valid1), 32'd0);
    chk({tag, "_data0"}, 32'(px_data0), 32'd0);
    chk({tag, "_fcnt0"}, 32'(fcnt0), 32'd0);
    chk({tag, "_fcnt1"}, 32'(fcnt1), 32'd0);
    chk({tag, "_flags0"}, {29'd0, ovr0, sf0, fd0}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    check_zero("reset");
    rst_n = 1'b1;
    enable = 1'b1;
    cyc(20);

    // Two full lines of known bytes.
    fill_line(0, 8, 8'h11, 8'h11);
    fill_line(1, 8, 8'h91, 1);
    drive_frame(2, 1'b1, -1, -1, -1);
    chk("t1_log0_size", 32'(log0.size()), 32'd8);
    if (log0.size() == 8) begin
      chk("t1_px0", log0[0].data, 32'h1122);
      chk("t1_px3", log0[3].data, 32'h7788);
      chk("t1_addr3", log0[3].addr, 32'd3);
      chk("t1_px4", log0[4].data, 32'h9192);
      chk("t1_px7", log0[7].data, 32'h9798);
      chk("t1_addr7", log0[7].addr, 32'd7);
    end
    chk("t1_log1_size", 32'(log1.size()), 32'd2);
    if (log1.size() == 2) chk("t1_d1_px1", log1[1].data, 32'h33);
    chk("t1_fcnt", 32'(fcnt0), 32'd1);

    // Stall the sink over pixel 1: pixel 0 is held, pixel 1 dropped.
    rdy_mode0 = 1;
    drive_frame(2, 1'b1, 1, 4, -1);
    chk("t2_log0_size", 32'(log0.size()), 32'd7);
    if (log0.size() >= 2) begin
      chk("t2_px0", log0[0].data, 32'h1122);
      chk("t2_px1", log0[1].data, 32'h5566);
      chk("t2_addr1", log0[1].addr, 32'd2);
    end
    chk("t2_overrun", 32'(ovr0), 32'd1);
    clear_errors();

    // Bytes equal to the column index, four lines.
    for (int r = 0; r < 4; r++) fill_line(r, 4, 0, 1);
    drive_frame(4, 1'b1, -1, -1, -1);
    chk("t3_log1_size", 32'(log1.size()), 32'd4);
    if (log1.size() == 4) begin
      chk("t3_px1", log1[1].data, 32'd2);
      chk("t3_px2", log1[2].data, 32'd0);
      chk("t3_addr3", log1[3].addr, 32'd3);
    end

    // Over-long line with a trailing half pixel.
    fill_line(0, 13, 8'h01, 1);
    fill_line(1, 4, 8'hA0, 1);
    drive_frame(2, 1'b1, -1, -1, -1);
    chk("t4_log0_size", 32'(log0.size()), 32'd6);
    if (log0.size() == 6) begin
      chk("t4_px3", log0[3].data, 32'h0708);
      chk("t4_px4", log0[4].data, 32'hA0A1);
      chk("t4_addr4", log0[4].addr, 32'd4);
    end

    // Short frame.
    clear_errors();
    fill_line(0, 8, 8'h40, 3);
    drive_frame(1, 1'b1, -1, -1, -1);
    chk("t5_short0", 32'(sf0), 32'd1);
    clear_errors();

    for (int f = 0; f < 20; f++) begin
      int nl;
      nl = $urandom_range(1, 5);
      fill_random(nl);
      drive_frame(nl, 1'b1, -1, -1, -1);
      if (f % 5 == 4) clear_errors();
    end

    // Drop enable mid-frame: the frame completes, the next one is ignored.
    fill_random(2);
    drive_frame(2, 1'b1, -1, -1, 1);
    chk("t7_idle0", 32'(st0), 32'd0);
    chk("t7_idle1", 32'(st1), 32'd0);
    fill_random(2);
    drive_frame(2, 1'b0, -1, -1, -1);
    chk("t7_fcnt_held", 32'(fcnt0), 32'(exp_cnt));
    enable = 1'b1;
    cyc(2);
    chk("t7_waitvs", 32'(st0), 32'd1);
    fill_random(3);
    drive_frame(3, 1'b1, -1, -1, -1);

    // Reset in the middle of a line.
    chk_en = 1'b0;
    rdy_mode0 = 1;
    vsync = 1'b0;
    cyc(10);
    href = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data = 8'(8'h55 + i * 8'h11);
      pclk = 1'b0;
      cyc(4);
      pclk = 1'b1;
      cyc(4);
    end
    chk("t8_capture", 32'(st0), 32'd2);
    chk("t8_valid", 32'(px_valid0), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
